// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, CHANNELS duty comparators,
// with period/duty/mode double-buffered and swapped in only at a period boundary.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      En,
  input  logic [WIDTH-1:0]          Period,
  input  logic [CHANNELS*WIDTH-1:0] Duty,
  input  logic                      Mode,
  input  logic                      Load,
  output logic                      LoadPending,
  output logic                      PeriodStart,
  output logic [CHANNELS-1:0]       Out
);

  // Idle covers reset and disabled cycles; the first enabled edge leaves it at count 0.
  typedef enum logic [1:0] {
    Idle,
    CountUp,
    CountDown
  } phase_e;

  phase_e                      phase_q, phase_d;
  logic [WIDTH-1:0]            cnt_q, cnt_d;
  logic [WIDTH-1:0]            actPeriod_q, actPeriod_d;
  logic [CHANNELS*WIDTH-1:0]   actDuty_q, actDuty_d;
  logic                        actMode_q, actMode_d;
  logic [WIDTH-1:0]            shPeriod_q, shPeriod_d;
  logic [CHANNELS*WIDTH-1:0]   shDuty_q, shDuty_d;
  logic                        shMode_q, shMode_d;
  logic                        pending_q, pending_d;
  logic                        start_q, start_d;
  logic [CHANNELS-1:0]         out_q, out_d;
  logic                        terminal;
  logic                        applyShadow;

  always_ff @(posedge Clk) begin
    if (reset) begin
      phase_q     <= Idle;
      cnt_q       <= '0;
      actPeriod_q <= '0;
      actDuty_q   <= '0;
      actMode_q   <= 1'b0;
      shPeriod_q  <= '0;
      shDuty_q    <= '0;
      shMode_q    <= 1'b0;
      pending_q   <= 1'b0;
      start_q     <= 1'b0;
      out_q       <= '0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      actPeriod_q <= actPeriod_d;
      actDuty_q   <= actDuty_d;
      actMode_q   <= actMode_d;
      shPeriod_q  <= shPeriod_d;
      shDuty_q    <= shDuty_d;
      shMode_q    <= shMode_d;
      pending_q   <= pending_d;
      start_q     <= start_d;
      out_q       <= out_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    actPeriod_d = actPeriod_q;
    actDuty_d   = actDuty_q;
    actMode_d   = actMode_q;
    shPeriod_d  = shPeriod_q;
    shDuty_d    = shDuty_q;
    shMode_d    = shMode_q;
    pending_d   = pending_q;
    start_d     = 1'b0;
    out_d       = '0;
    applyShadow = 1'b0;

    // Center mode with P <= 1 never counts down, so its terminal cycle is count == P.
    terminal = ((cnt_q == actPeriod_q) && (!actMode_q || (actPeriod_q <= WIDTH'(1)))) ||
               (actMode_q && (phase_q == CountDown) && (cnt_q == WIDTH'(1)));

    if (Load) begin
      shPeriod_d = Period;
      shDuty_d   = Duty;
      shMode_d   = Mode;
    end

    if (!En) begin
      phase_d     = Idle;
      cnt_d       = '0;
      applyShadow = Load || pending_q;
    end else if (phase_q == Idle) begin
      phase_d     = CountUp;
      cnt_d       = '0;
      applyShadow = Load || pending_q;
    end else if (terminal) begin
      phase_d     = CountUp;
      cnt_d       = '0;
      applyShadow = Load || pending_q;
    end else if (!actMode_q) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if ((phase_q == CountUp) && (cnt_q == actPeriod_q)) begin
      phase_d = CountDown;
      cnt_d   = cnt_q - WIDTH'(1);
    end else if (phase_q == CountUp) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
    end

    // A Load seen on the applying edge bypasses the shadow and is used directly.
    if (applyShadow) begin
      actPeriod_d = Load ? Period : shPeriod_q;
      actDuty_d   = Load ? Duty   : shDuty_q;
      actMode_d   = Load ? Mode   : shMode_q;
      pending_d   = 1'b0;
    end else if (Load) begin
      pending_d = 1'b1;
    end

    start_d = En && (cnt_d == '0);
    for (int i = 0; i < CHANNELS; i++) begin
      out_d[i] = En && (cnt_d < actDuty_d[i*WIDTH +: WIDTH]);
    end
  end

  assign LoadPending = pending_q;
  assign PeriodStart = start_q;
  assign Out         = out_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus random traffic, all
// compared each cycle against a position-in-period reference model.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            en = 1'b0;
  logic [W-1:0]    period = '0;
  logic [CH*W-1:0] duty = '0;
  logic            mode = 1'b0;
  logic            load = 1'b0;
  logic            loadPending;
  logic            periodStart;
  logic [CH-1:0]   pwmOut;

  int compared = 0;
  int mismatched = 0;

  // Reference model: position k inside the current period plus active/shadow settings.
  int            mK, mP, sP;
  logic          mMode, sMode, mRun, mPend;
  int            mD[CH];
  int            sD[CH];
  logic [CH-1:0] expOut;
  logic          expPs, expLp;

  pwm_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .Clk(clock), .reset(reset), .En(en), .Period(period), .Duty(duty),
    .Mode(mode), .Load(load), .LoadPending(loadPending),
    .PeriodStart(periodStart), .Out(pwmOut)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic enIn, input logic loadIn, input int periodIn,
                               input logic [CH*W-1:0] dutyIn, input logic modeIn);
    en     = enIn;
    load   = loadIn;
    period = W'(periodIn);
    duty   = dutyIn;
    mode   = modeIn;
  endtask

  function automatic int periodLen(input int p, input logic m);
    if (p == 0) return 1;
    return m ? 2 * p : p + 1;
  endfunction

  task automatic modelStep();
    int   len;
    int   cnt;
    logic applyNow;
    if (reset) begin
      mK = 0; mP = 0; sP = 0; mMode = 0; sMode = 0; mRun = 0; mPend = 0;
      for (int i = 0; i < CH; i++) begin
        mD[i] = 0;
        sD[i] = 0;
      end
      expOut = '0; expPs = 0; expLp = 0;
      return;
    end
    len      = periodLen(mP, mMode);
    applyNow = (!en || !mRun || (mK == len - 1)) && (load || mPend);
    if (applyNow) begin
      mP    = load ? int'(period) : sP;
      mMode = load ? mode : sMode;
      for (int i = 0; i < CH; i++) mD[i] = load ? int'(duty[i*W +: W]) : sD[i];
    end
    if (load) begin
      sP    = int'(period);
      sMode = mode;
      for (int i = 0; i < CH; i++) sD[i] = int'(duty[i*W +: W]);
    end
    mPend = applyNow ? 1'b0 : (load ? 1'b1 : mPend);
    if (!en) begin
      mK = 0; mRun = 0;
    end else if (!mRun) begin
      mK = 0; mRun = 1;
    end else begin
      mK = (mK == len - 1) ? 0 : mK + 1;
    end
    // Center mode folds the second half of the period back down toward zero.
    cnt = (mMode && mK > mP) ? 2 * mP - mK : mK;
    for (int i = 0; i < CH; i++) expOut[i] = en && (cnt < mD[i]);
    expPs = en && (mK == 0);
    expLp = mPend;
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
    checkOutput("out", 32'(pwmOut), 32'(expOut));
    checkOutput("pstart", 32'(periodStart), 32'(expPs));
    checkOutput("lpend", 32'(loadPending), 32'(expLp));
  endtask

  task automatic waitStart(input string tag);
    bit found = 0;
    for (int n = 0; n < 600 && !found; n++) begin
      tick();
      if (periodStart === 1'b1) found = 1;
    end
    if (!found) checkOutput(tag, 32'd0, 32'd1);
  endtask

  localparam logic [CH*W-1:0] DutyA = {8'd9, 8'd5, 8'd2, 8'd0};
  localparam logic [CH*W-1:0] DutyB = {8'd9, 8'd5, 8'd4, 8'd0};
  localparam logic [CH*W-1:0] DutyC = {8'd0, 8'd0, 8'd0, 8'd2};

  initial begin
    int psCnt, lpCnt, o0, o1, o2;
    int p, dmax;
    logic [CH*W-1:0] rd;

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Edge mode P=4 with mixed duties.
    applyStimulus(0, 1, 4, DutyA, 0); tick();
    applyStimulus(1, 0, 4, DutyA, 0);
    for (int n = 0; n < 10; n++) tick();
    psCnt = 0; o0 = 0; o1 = 0; o2 = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      psCnt += int'(periodStart); o0 += int'(pwmOut[0]);
      o1 += int'(pwmOut[1]); o2 += int'(pwmOut[2]);
    end
    checkOutput("c1_ps", psCnt, 2);
    checkOutput("c1_out0", o0, 0);
    checkOutput("c1_out1", o1, 4);
    checkOutput("c1_out2", o2, 10);

    // Load mid-period stays pending until the boundary.
    waitStart("c2_wait"); tick();
    applyStimulus(1, 1, 4, DutyB, 0); tick();
    applyStimulus(1, 0, 4, DutyB, 0);
    lpCnt = int'(loadPending); o1 = int'(pwmOut[1]);
    for (int n = 0; n < 7; n++) begin
      tick();
      lpCnt += int'(loadPending); o1 += int'(pwmOut[1]);
    end
    checkOutput("c2_lp", lpCnt, 3);
    checkOutput("c2_out1", o1, 4);

    // Center mode P=4, D0=2.
    applyStimulus(1, 1, 4, DutyC, 1); tick();
    applyStimulus(1, 0, 4, DutyC, 1);
    waitStart("c3_wait");
    psCnt = int'(periodStart); o0 = int'(pwmOut[0]);
    for (int n = 0; n < 15; n++) begin
      tick();
      psCnt += int'(periodStart); o0 += int'(pwmOut[0]);
    end
    checkOutput("c3_ps", psCnt, 2);
    checkOutput("c3_out0", o0, 6);

    // Drop En mid-period and bring it back.
    applyStimulus(1, 1, 4, DutyA, 0); tick();
    applyStimulus(1, 0, 4, DutyA, 0);
    waitStart("c4_wait"); tick(); tick();
    applyStimulus(0, 0, 4, DutyA, 0); tick();
    checkOutput("c4_off", 32'(pwmOut), 32'd0);
    tick();
    applyStimulus(1, 0, 4, DutyA, 0); tick();
    checkOutput("c4_ps", 32'(periodStart), 32'd1);
    checkOutput("c4_out", 32'(pwmOut), 32'b1110);
    for (int n = 0; n < 6; n++) tick();

    // Reset mid-period with En held high.
    waitStart("c5_wait"); tick();
    reset = 1'b1; tick();
    checkOutput("c5_out", 32'(pwmOut), 32'd0);
    checkOutput("c5_lp", 32'(loadPending), 32'd0);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    checkOutput("c5_out2", 32'(pwmOut), 32'd0);
    checkOutput("c5_ps", 32'(periodStart), 32'd1);

    // Load exactly in the terminal-count cycle.
    applyStimulus(1, 1, 4, DutyA, 0); tick();
    applyStimulus(1, 0, 4, DutyA, 0);
    waitStart("c6_wait");
    for (int n = 0; n < 4; n++) tick();
    applyStimulus(1, 1, 2, DutyA, 0); tick();
    checkOutput("c6_ps", 32'(periodStart), 32'd1);
    checkOutput("c6_lp", 32'(loadPending), 32'd0);
    applyStimulus(1, 0, 2, DutyA, 0);
    psCnt = 0; lpCnt = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      psCnt += int'(periodStart); lpCnt += int'(loadPending);
    end
    checkOutput("c6_ps3", psCnt, 2);
    checkOutput("c6_lpnever", lpCnt, 0);

    // Random traffic, including the full-range period.
    for (int n = 0; n < 1500; n++) begin
      p    = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 6);
      dmax = (p + 2 > 255) ? 255 : p + 2;
      for (int i = 0; i < CH; i++) rd[i*W +: W] = W'($urandom_range(0, dmax));
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), p, rd,
                    1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    load  = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator; successor to the single-channel PWM block. One shared period counter drives CHANNELS independent duty comparators. Period, duty and alignment mode are double-buffered: written to shadow registers and applied only at a period boundary. Sits between the control/register logic and the actuator pins; PeriodStart lets downstream logic sample in sync with the PWM frame.

Parameters:
CHANNELS, 4, number of independent PWM outputs
WIDTH, 8, bit width of counter, period and each duty value

Ports:
Clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
En  input  1  run enable; low forces counter to 0 and all outputs low
Period  input  WIDTH  terminal count P, captured into shadow on Load
Duty  input  CHANNELS*WIDTH  per-channel duty D_i; channel i occupies bits [i*WIDTH +: WIDTH]
Mode  input  1  0 = edge-aligned, 1 = center-aligned; captured into shadow on Load
Load  input  1  single-cycle strobe; captures Period, Duty and Mode into shadow
LoadPending  output  1  high from the cycle after Load until the shadow is applied
PeriodStart  output  1  one-cycle pulse on the first cycle of each period
Out  output  CHANNELS  PWM outputs, registered

Behaviour:
- Reset, sampled on a clock edge:
  - counter = 0, direction = up.
  - Active and shadow P, D_i and Mode all = 0.
  - LoadPending = 0, PeriodStart = 0, Out = 0.
  - Reset asserted mid-period takes effect at the next edge. No partial period completes.
- Edge mode counter: runs 0,1,…,P, then wraps to 0. Period = P+1 cycles.
- Center mode counter: runs 0,1,…,P, then P-1,…,1, then 0. Period = 2P cycles.
- P = 0 in either mode: counter stays at 0 and the period is 1 cycle. PeriodStart stays high every cycle while En = 1.
- Out timing: Out is registered and aligned with the counter. In any cycle, Out[i] = (counter < active D_i), using the counter value of that same cycle.
- Edge mode duty: Out[i] is high for exactly min(D_i, P+1) cycles per period, starting at counter = 0.
  - D_i = 0: always low.
  - D_i > P: always high.
- Center mode duty: the high pulse is symmetric about counter = 0.
- Terminal-count cycle:
  - Edge mode: counter = P.
  - Center mode: counter = 1 while counting down, or counter = P when P ≤ 1.
- Boundary update: if LoadPending = 1 or Load = 1 in the terminal-count cycle, shadow values are copied to active on that edge. The next period (counter = 0) uses the new values, and LoadPending clears.
  - Load sampled in the terminal-count cycle bypasses the shadow and applies at that same boundary.
- Load while already pending: overwrites the shadow; LoadPending stays high. Only the last values written are applied.
- Mode change at a boundary: the counter restarts at 0 with direction = up.
- En = 0: counter held at 0, direction = up, Out = 0, PeriodStart = 0.
  - Load while En = 0 applies on the next edge; LoadPending is never raised.
- En 0→1: the first enabled cycle has counter = 0 and PeriodStart = 1.
- En 1→0 mid-period: on the next edge the counter = 0 and Out = 0. Any pending shadow is applied on that edge.
- Counter arithmetic is unsigned WIDTH-bit. P = 2^WIDTH−1 is legal; there is no overflow because the wrap happens at P.
- Outputs are never X after reset, regardless of the state of the X/Z inputs.

Test Plan:
1. WIDTH=8, CHANNELS=4. Reset, then Period=4, Duty={9,5,2,0} (ch3..ch0), Mode=0, Load, En=1 → period 5 cycles; Out[0] always 0; Out[1] high 2 / low 3; Out[2] and Out[3] always high; PeriodStart pulses every 5 cycles.
2. While running case 1, Load with ch1 duty 4 at counter=1 → current period keeps 2 high cycles; LoadPending=1 through counter=4; next period has 4 high cycles; LoadPending=0 from counter=0.
3. Period=4, D_0=2, Mode=1 → counter sequence 0,1,2,3,4,3,2,1 repeating; Out[0] high at counts 1(down),0,1(up), i.e. 3 of 8 cycles contiguous; PeriodStart every 8 cycles.
4. Drop En at counter=2 of case 1 → next cycle counter=0 and Out=0000; raise En again → first cycle counter=0, PeriodStart=1, and the waveform repeats exactly as in case 1.
5. Assert reset for 1 cycle mid-period, keeping En=1 → Out=0 and LoadPending=0 from the next edge; Out stays 0 (active duties = 0, P = 0) until a new Load.
6. Load with Period=2 exactly in the terminal-count cycle (counter=4) → the very next cycle starts a 3-cycle period; LoadPending never goes high.
